// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace monitor: state encoding, flag bit
// positions and the packed record width.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } traceState_e;

    localparam int FLAG_REGWRITE = 0;
    localparam int FLAG_MEMREAD  = 1;
    localparam int FLAG_MEMWRITE = 2;
    localparam int FLAG_HLT      = 3;
    localparam int NUM_FLAGS     = 4;

    // Record layout, MSB first: flags, cycle, regSel, regData, memAddr, memData
    function automatic int recWidth(int cntW, int regW, int dataW, int addrW);
        return NUM_FLAGS + cntW + regW + dataW + addrW + dataW;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable without a separate count.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr, rdPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doWrite, doRead;

    assign empty   = (wrPtr == rdPtr);
    assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign doRead  = pop && !empty;
    // A pop in the same cycle frees the slot the push lands in
    assign doWrite = push && (!full || doRead);
    assign rdata   = mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doWrite) wrPtr <= wrPtr + (AW+1)'(1);
            if (doRead)  rdPtr <= rdPtr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite && !flush) mem[wrPtr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/commit_trace_unit.sv
// Commit-trace monitor: stamps MEM/WB events with a RUN cycle number, keeps
// instruction/cycle/drop counters and buffers records for a valid/ready consumer.
//
// state   | meaning
// IDLE    | waiting for start; events ignored
// RUN     | counting cycles, recording events
// HALTED  | hlt seen; counters frozen, draining
// TIMEOUT | watchdog limit reached; counters frozen, draining
module commit_trace_unit
    import trace_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              clear,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_reg_sel,
    input  logic [DATA_W-1:0] wb_reg_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              hlt,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [3:0]        rec_flags,
    output logic [CNT_W-1:0]  rec_cycle,
    output logic [REG_W-1:0]  rec_reg_sel,
    output logic [DATA_W-1:0] rec_reg_data,
    output logic [ADDR_W-1:0] rec_mem_addr,
    output logic [DATA_W-1:0] rec_mem_data,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  inst_count,
    output logic [CNT_W-1:0]  dropped_count,
    output logic              overflow,
    output logic [1:0]        state,
    output logic              done,
    output logic              timeout
);
    localparam int RW = recWidth(CNT_W, REG_W, DATA_W, ADDR_W);

    traceState_e      stateQ, stateD;
    logic [CNT_W-1:0] cycleQ, instQ, dropQ, cycleNext;
    logic             overflowQ;
    logic             inRun, anyEvent, pushReq, doPop, dropNow;
    logic             fifoFull, fifoEmpty;
    logic [3:0]       flags;
    logic [RW-1:0]    pushRec, headRec, outRec;
    logic [REG_W-1:0]  pkRegSel;
    logic [DATA_W-1:0] pkRegData, pkMemData;
    logic [ADDR_W-1:0] pkMemAddr;

    assign inRun     = (stateQ == RUN);
    assign anyEvent  = wb_regwrite | mem_read | mem_write | hlt;
    assign pushReq   = inRun && anyEvent && !clear;
    assign doPop     = !fifoEmpty && rec_ready;
    assign dropNow   = pushReq && fifoFull && !doPop;
    assign cycleNext = (cycleQ == '1) ? cycleQ : cycleQ + CNT_W'(1);

    always_comb begin
        stateD = stateQ;
        if (clear) begin
            stateD = IDLE;
        end else begin
            case (stateQ)
                IDLE: if (start) stateD = RUN;
                RUN: begin
                    if (hlt)                                stateD = HALTED;
                    else if (cycleNext >= CNT_W'(MAX_CYCLES)) stateD = TIMEOUT;
                end
                default: stateD = stateQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycleQ    <= '0;
            instQ     <= '0;
            dropQ     <= '0;
            overflowQ <= 1'b0;
        end else if (clear) begin
            cycleQ    <= '0;
            instQ     <= '0;
            dropQ     <= '0;
            overflowQ <= 1'b0;
        end else if (inRun) begin
            cycleQ <= cycleNext;
            if ((hlt || wb_regwrite || mem_write) && instQ != '1)
                instQ <= instQ + CNT_W'(1);
            if (dropNow) begin
                overflowQ <= 1'b1;
                if (dropQ != '1) dropQ <= dropQ + CNT_W'(1);
            end
        end
    end

    // Fields belonging to inactive flags are packed as zero
    always_comb begin
        flags                = '0;
        flags[FLAG_REGWRITE] = wb_regwrite;
        flags[FLAG_MEMREAD]  = mem_read;
        flags[FLAG_MEMWRITE] = mem_write;
        flags[FLAG_HLT]      = hlt;
        pkRegSel  = wb_regwrite ? wb_reg_sel  : '0;
        pkRegData = wb_regwrite ? wb_reg_data : '0;
        pkMemAddr = (mem_read || mem_write) ? mem_addr : '0;
        pkMemData = '0;
        if (mem_write)     pkMemData = mem_wdata;
        else if (mem_read) pkMemData = mem_rdata;
    end

    assign pushRec = {flags, cycleNext, pkRegSel, pkRegData, pkMemAddr, pkMemData};

    trace_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) uFifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushReq),
        .pop   (doPop),
        .flush (clear),
        .wdata (pushRec),
        .rdata (headRec),
        .full  (fifoFull),
        .empty (fifoEmpty)
    );

    assign outRec    = fifoEmpty ? '0 : headRec;
    assign {rec_flags, rec_cycle, rec_reg_sel, rec_reg_data, rec_mem_addr, rec_mem_data} = outRec;
    assign rec_valid     = !fifoEmpty;
    assign cycle_count   = cycleQ;
    assign inst_count    = instQ;
    assign dropped_count = dropQ;
    assign overflow      = overflowQ;
    assign state         = stateQ;
    assign timeout       = (stateQ == TIMEOUT);
    assign done          = ((stateQ == HALTED) || (stateQ == TIMEOUT)) && fifoEmpty;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed plus randomized bench for commit_trace_unit against a queue-based
// reference model of the trace rules (DEPTH=4, MAX_CYCLES=10).
module tb_commit_trace_unit;
    localparam int DEPTH = 4;
    localparam int MAXC  = 10;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 0, clear = 0, rec_ready = 0;
    logic        wb_regwrite = 0, mem_read = 0, mem_write = 0, hlt = 0;
    logic [3:0]  wb_reg_sel = '0;
    logic [15:0] wb_reg_data = '0, mem_addr = '0, mem_wdata = '0, mem_rdata = '0;
    logic        rec_valid, overflow, done, timeout;
    logic [3:0]  rec_flags, rec_reg_sel;
    logic [31:0] rec_cycle, cycle_count, inst_count, dropped_count;
    logic [15:0] rec_reg_data, rec_mem_addr, rec_mem_data;
    logic [1:0]  state;

    commit_trace_unit #(.DEPTH(DEPTH), .MAX_CYCLES(MAXC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .wb_regwrite(wb_regwrite), .wb_reg_sel(wb_reg_sel), .wb_reg_data(wb_reg_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_flags(rec_flags),
        .rec_cycle(rec_cycle), .rec_reg_sel(rec_reg_sel), .rec_reg_data(rec_reg_data),
        .rec_mem_addr(rec_mem_addr), .rec_mem_data(rec_mem_data),
        .cycle_count(cycle_count), .inst_count(inst_count), .dropped_count(dropped_count),
        .overflow(overflow), .state(state), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;
        logic [31:0] cyc;
        logic [3:0]  regSel;
        logic [15:0] regData, memAddr, memData;
    } rec_t;

    rec_t q[$];
    int   mState, mCycle, mInst, mDrop, mOvf;
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mReset();
        q.delete();
        mState = 0; mCycle = 0; mInst = 0; mDrop = 0; mOvf = 0;
    endtask

    // One clock of the trace rules, applied to the inputs currently driven
    task automatic modelStep();
        rec_t r;
        int   origSize = q.size();
        bit   popNow = (origSize > 0) && rec_ready;
        bit   ev = wb_regwrite | mem_read | mem_write | hlt;
        if (clear) begin
            mReset();
            return;
        end
        if (popNow) void'(q.pop_front());
        if (mState == 1) begin
            mCycle = mCycle + 1;
            if (ev) begin
                r.flags   = {hlt, mem_write, mem_read, wb_regwrite};
                r.cyc     = mCycle;
                r.regSel  = wb_regwrite ? wb_reg_sel : 4'h0;
                r.regData = wb_regwrite ? wb_reg_data : 16'h0;
                r.memAddr = (mem_read | mem_write) ? mem_addr : 16'h0;
                r.memData = mem_write ? mem_wdata : (mem_read ? mem_rdata : 16'h0);
                if (origSize < DEPTH || popNow) q.push_back(r);
                else begin mDrop++; mOvf = 1; end
            end
            if (hlt | wb_regwrite | mem_write) mInst++;
            if (hlt) mState = 2;
            else if (mCycle >= MAXC) mState = 3;
        end else if (mState == 0 && start) begin
            mState = 1;
        end
    endtask

    task automatic checkAll();
        bit hv = q.size() > 0;
        chk("rec_valid", rec_valid, hv);
        chk("rec_flags", rec_flags, hv ? q[0].flags : 4'h0);
        chk("rec_cycle", rec_cycle, hv ? q[0].cyc : 32'h0);
        chk("rec_reg_sel", rec_reg_sel, hv ? q[0].regSel : 4'h0);
        chk("rec_reg_data", rec_reg_data, hv ? q[0].regData : 16'h0);
        chk("rec_mem_addr", rec_mem_addr, hv ? q[0].memAddr : 16'h0);
        chk("rec_mem_data", rec_mem_data, hv ? q[0].memData : 16'h0);
        chk("cycle_count", cycle_count, mCycle);
        chk("inst_count", inst_count, mInst);
        chk("dropped_count", dropped_count, mDrop);
        chk("overflow", overflow, mOvf);
        chk("state", state, mState);
        chk("timeout", timeout, mState == 3);
        chk("done", done, (mState >= 2) && !hv);
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic zeroEv();
        wb_regwrite = 0; mem_read = 0; mem_write = 0; hlt = 0;
        wb_reg_sel = '0; wb_reg_data = '0; mem_addr = '0; mem_wdata = '0; mem_rdata = '0;
        start = 0; clear = 0;
    endtask

    task automatic regEv(input logic [3:0] sel, input logic [15:0] d);
        zeroEv(); wb_regwrite = 1; wb_reg_sel = sel; wb_reg_data = d;
    endtask

    task automatic restart();
        zeroEv(); clear = 1; tick();
        clear = 0; start = 1; tick();
        start = 0;
    endtask

    initial begin
        mReset();
        #12;
        checkAll();
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Single register write, stamped with RUN cycle 1
        start = 1; rec_ready = 1; tick();
        regEv(4'd3, 16'h1234); tick();
        chk("first_flags", rec_flags, 4'b0001);
        chk("first_cycle", rec_cycle, 32'd1);
        chk("first_inst", inst_count, 32'd1);
        zeroEv(); tick();

        // Load then store; only the store counts as an instruction
        zeroEv(); mem_read = 1; mem_addr = 16'h0040; mem_rdata = 16'hBEEF; tick();
        chk("load_flags", rec_flags, 4'b0010);
        zeroEv(); mem_write = 1; mem_addr = 16'h0042; mem_wdata = 16'h00AA; mem_rdata = 16'h5555; tick();
        chk("store_flags", rec_flags, 4'b0100);
        chk("store_inst", inst_count, 32'd2);
        zeroEv(); mem_read = 1; mem_write = 1; mem_addr = 16'h7; mem_wdata = 16'h11; mem_rdata = 16'h22; tick();
        zeroEv(); tick(); tick();

        // Overflow: 6 events into a 4-deep FIFO with no consumer
        restart(); rec_ready = 0;
        for (int i = 0; i < 6; i++) begin regEv(4'(i), 16'($urandom)); tick(); end
        zeroEv();
        chk("ovf_dropped", dropped_count, 32'd2);
        chk("ovf_flag", overflow, 1'b1);
        rec_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", rec_cycle, 32'(i + 1));
            tick();
        end

        // Halt with records pending; later events ignored, done after last pop
        restart(); rec_ready = 0;
        for (int i = 0; i < 3; i++) begin regEv(4'(i + 8), 16'($urandom)); tick(); end
        zeroEv(); hlt = 1; tick();
        chk("halt_state", state, 2'd2);
        regEv(4'd1, 16'hFFFF); tick(); tick();
        zeroEv(); rec_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("halt_not_done", done, 1'b0);
            tick();
        end
        chk("halt_done", done, 1'b1);

        // Watchdog
        restart();
        for (int i = 0; i < 12; i++) tick();
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_cycles", cycle_count, 32'd10);

        // Async reset with a full FIFO, then clear with an event pending
        restart(); rec_ready = 0;
        for (int i = 0; i < 5; i++) begin regEv(4'(i), 16'($urandom)); tick(); end
        #3 rst_n = 0;
        #1 mReset(); checkAll();
        @(negedge clk); rst_n = 1;
        zeroEv(); start = 1; tick();
        for (int i = 0; i < 5; i++) begin regEv(4'(i), 16'($urandom)); tick(); end
        regEv(4'd9, 16'h9999); start = 1; clear = 1; tick();
        chk("clear_state", state, 2'd0);

        // Randomized traffic
        zeroEv(); clear = 1; tick();
        for (int i = 0; i < 600; i++) begin
            zeroEv();
            clear       = ($urandom_range(0, 29) == 0);
            start       = ($urandom_range(0, 2) == 0);
            rec_ready   = $urandom_range(0, 1);
            wb_regwrite = $urandom_range(0, 1);
            mem_read    = ($urandom_range(0, 2) == 0);
            mem_write   = ($urandom_range(0, 2) == 0);
            hlt         = ($urandom_range(0, 11) == 0);
            wb_reg_sel  = 4'($urandom);
            wb_reg_data = 16'($urandom);
            mem_addr    = 16'($urandom);
            mem_wdata   = 16'($urandom);
            mem_rdata   = 16'($urandom);
            if (mState >= 2 && q.size() == 0 && $urandom_range(0, 1) == 1) clear = 1;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_unit.md
# commit_trace_unit

Synthesizable commit-trace monitor that replaces the per-cycle trace logging currently done in the CPU testbench. It sits beside the pipeline's MEM and WB stages and watches register writes, memory reads, memory writes and halt. It stamps each active cycle with a cycle number, keeps instruction and cycle counters, and buffers records in a FIFO drained over a valid/ready port. It adds programmable widths and depth, overflow accounting, a cycle watchdog and a halt/drain completion handshake.

## Interface
- DATA_W, 16: register/memory data width
- ADDR_W, 16: memory address width
- REG_W, 4: register index width
- DEPTH, 16: FIFO entries; power of two, ≥2
- CNT_W, 32: cycle/instruction/drop counter width
- MAX_CYCLES, 100000: watchdog limit in RUN cycles
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves IDLE
- clear  in  1  synchronous flush to IDLE; highest priority after reset
- wb_regwrite  in  1  register file written this cycle
- wb_reg_sel  in  REG_W  register written
- wb_reg_data  in  DATA_W  value written
- mem_read, mem_write  in  1 each  memory access in MEM stage
- mem_addr  in  ADDR_W  memory address
- mem_wdata, mem_rdata  in  DATA_W  store data / load data
- hlt  in  1  halt in MEM/WB
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head
- rec_flags  out  4  {hlt, mem_write, mem_read, regwrite}
- rec_cycle  out  CNT_W  cycle stamp
- rec_reg_sel, rec_reg_data  out  REG_W, DATA_W  register fields
- rec_mem_addr, rec_mem_data  out  ADDR_W, DATA_W  memory fields
- cycle_count, inst_count, dropped_count  out  CNT_W each
- overflow  out  1  sticky: a record was dropped
- state  out  2  current state
- done  out  1  halted or timed out, and FIFO empty
- timeout  out  1  watchdog fired

## Operation
- States: IDLE=0, RUN=1, HALTED=2, TIMEOUT=3.
- IDLE→RUN on start. RUN→HALTED on a cycle with hlt=1. RUN→TIMEOUT when cycle_count reaches MAX_CYCLES without hlt. HALTED and TIMEOUT are exit-only via clear or reset.
- Event cycle: RUN and any of regwrite/mem_read/mem_write/hlt asserted. One record is pushed per event cycle.
- Record content:
  - flags: the four input bits.
  - rec_cycle: cycle_count+1, so the first RUN cycle is stamped 1.
  - Unused fields are zero.
  - rec_mem_data = mem_wdata if mem_write, else mem_rdata if mem_read. If both are set, both flags are set and wdata is stored.
- inst_count increments in RUN on hlt|regwrite|mem_write; mem_read alone does not count.
- cycle_count increments on every RUN cycle, including the halt cycle, and then freezes.
- In IDLE, HALTED and TIMEOUT all event inputs are ignored. Draining continues in HALTED and TIMEOUT.
- FIFO full on push without a pop in the same cycle: the record is dropped, overflow sets, dropped_count increments. Full with a simultaneous pop: push accepted.
- All counters saturate at all-ones.
- The hlt record is subject to the same drop rule; the HALTED transition happens regardless.
- done = (state==HALTED || state==TIMEOUT) && FIFO empty. timeout = (state==TIMEOUT).
- clear: empties FIFO, zeroes counters, clears overflow, goes to IDLE.

## Timing
- Reset (async assert, sync release): state IDLE, all counters 0, overflow 0, timeout 0, done 0, rec_valid 0, all rec_* 0.
- Push at the edge ending event cycle N. The record is visible on rec_* in cycle N+1 if the FIFO was empty.
- Head is show-ahead. rec_* must be stable while rec_valid && !rec_ready. Pop occurs on an edge with rec_valid && rec_ready.
- Throughput is one push and one pop per cycle. No combinational path exists from rec_ready to rec_valid.
- start in the same cycle as clear is ignored. start outside IDLE is ignored.
- clear mid-RUN takes effect at the next edge; events in that cycle are discarded.

## Structure
- Shared package `trace_pkg`: state encoding, flag bit indices, record struct/width function.
- Sub-module `trace_fifo`:
  - synchronous show-ahead FIFO, parameters WIDTH and DEPTH
  - ports: push, pop, full, empty, flush
  - read/write pointers carry one extra bit for full/empty detection
- Top level holds the FSM, counters and record packing.

## Test plan
- Reset, start, reg write r3=0x1234 in RUN cycle 1, rec_ready=1 → one record with flags=0001, cycle=1, reg_sel=3, data=0x1234; inst_count=1.
- Load 0x0040 returning 0xBEEF, then store 0x0042←0x00AA → flags 0010 then 0100 with correct addr/data; inst_count counts only the store.
- DEPTH=4, rec_ready=0, 6 event cycles → 4 records kept, dropped_count=2, overflow=1. Then raise rec_ready → records stamped 1..4 drained in order.
- hlt with 3 records pending → state=HALTED in the next cycle, cycle_count frozen, done rises only after the 4th pop; events after the halt produce nothing.
- MAX_CYCLES=10, no hlt → TIMEOUT after the 10th RUN cycle, timeout=1, cycle_count=10.
- rst_n pulsed low mid-RUN with a full FIFO → all outputs return to reset values immediately; clear does the same at the next edge.
